four_req_priority_arbiter: RTL and testbench

//  Sequences access to one shared resource among four requesters using a
//  4-to-2 priority-encoder selection core with a registered grant/hold FSM.
//  Two modes: fixed priority, where req[3] is highest (same ordering as the

---
 rtl/four_req_priority_arbiter.sv | 150 +++++++++++++++
 tb/tb_four_req_priority_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/four_req_priority_arbiter.sv
// Four-requester arbiter for one shared resource.
// Fixed-priority (3 > 2 > 1 > 0) or round-robin selection feeds a registered
// IDLE/BUSY grant FSM. A per-grant hold limit lets waiting requesters
// preempt a long-running holder. MAX_HOLD = 0 disables preemption.
module four_req_priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [3:0] MaxHold     = 4'(MAX_HOLD);
  localparam logic       HoldLimited = (MAX_HOLD != 0);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gntId_q, gntId_d;
  logic       valid_q, valid_d;
  logic [3:0] holdCnt_q, holdCnt_d;
  logic [1:0] lastId_q, lastId_d;

  logic       holderReq;
  logic [3:0] others;
  logic       takeGrant;
  logic [3:0] takeMask;
  logic [1:0] newId;

  // Picks the winner from a non-empty mask. Fixed mode takes the highest
  // set index. Round-robin mode searches upward from the slot after the
  // last winner and wraps around, so the last winner is checked last.
  function automatic logic [1:0] selIndex(input logic [3:0] mask,
                                          input logic       rr,
                                          input logic [1:0] last);
    logic [1:0] result;
    logic [1:0] idx;
    logic       found;
    result = 2'd0;
    found  = 1'b0;
    if (!rr) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) result = 2'(i);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (!found && mask[idx]) begin
          result = idx;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  // The holder's own request and the other requesters. Together they decide
  // between holding, releasing and preempting.
  assign holderReq = req[gntId_q];
  assign others    = req & ~(4'b0001 << gntId_q);
  assign newId     = selIndex(takeMask, mode, lastId_q);

  // Computes the next grant state. A fresh grant always comes from a
  // non-empty mask of live requests, so it never goes to an idle requester.
  // When a release and an expiry happen in the same cycle, the release wins.
  always_comb begin
    state_d   = state_q;
    gntId_d   = gntId_q;
    valid_d   = valid_q;
    holdCnt_d = holdCnt_q;
    lastId_d  = lastId_q;
    takeGrant = 1'b0;
    takeMask  = 4'b0000;

    case (state_q)
      IDLE: begin
        if (|req) begin
          takeGrant = 1'b1;
          takeMask  = req;
        end
      end
      BUSY: begin
        if (!holderReq) begin
          if (|others) begin
            takeGrant = 1'b1;
            takeMask  = others;
          end else begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            gntId_d   = 2'd0;
            holdCnt_d = 4'd0;
          end
        end else if (HoldLimited && (holdCnt_q == MaxHold) && (|others)) begin
          takeGrant = 1'b1;
          takeMask  = others;
        end else if (holdCnt_q != 4'd15) begin
          holdCnt_d = holdCnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        gntId_d = 2'd0;
      end
    endcase

    if (takeGrant) begin
      state_d   = BUSY;
      gntId_d   = newId;
      valid_d   = 1'b1;
      holdCnt_d = 4'd1;
      lastId_d  = newId;
    end

    gnt_d = valid_d ? (4'b0001 << gntId_d) : 4'b0000;
  end

  // Registers the FSM and the grant outputs. Reset overrides everything and
  // drops any active grant at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gntId_q   <= 2'd0;
      valid_q   <= 1'b0;
      holdCnt_q <= 4'd0;
      lastId_q  <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      valid_q   <= valid_d;
      holdCnt_q <= holdCnt_d;
      lastId_q  <= lastId_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gntId_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_four_req_priority_arbiter.sv
// Testbench for four_req_priority_arbiter.
// Two instances share one stimulus stream: one with a hold limit of 2 and
// one with no limit. An abstract reference model predicts every cycle's
// outputs. A monitor compares those predictions against both instances.
module tb_four_req_priority_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       checkId;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       mode;
  logic [3:0] gntA, gntB;
  logic [1:0] idA, idB;
  logic       validA, validB;

  int checks   = 0;
  int failures = 0;

  exp_t qA[$];
  exp_t qB[$];

  int mHolder[2];
  int mCnt[2];
  int mLast[2];
  int mMax[2];

  four_req_priority_arbiter #(.MAX_HOLD(2)) dutA (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gntA), .gnt_id(idA), .valid(validA)
  );

  four_req_priority_arbiter #(.MAX_HOLD(0)) dutB (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .gnt(gntB), .gnt_id(idB), .valid(validB)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Returns the winner from a request mask, using the arbitration rules.
  // Returns -1 when the mask is empty.
  function automatic int pick(input int mask, input int md, input int last);
    if (md == 0) begin
      for (int i = 3; i >= 0; i--) if (((mask >> i) & 1) != 0) return i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (last + k) % 4;
        if (((mask >> idx) & 1) != 0) return idx;
      end
    end
    return -1;
  endfunction

  // Advances the reference model by one clock edge and returns the
  // outputs it predicts after that edge.
  function automatic exp_t modelStep(input int w, input logic r,
                                     input logic [3:0] rq, input logic md);
    exp_t e;
    int reqI, others, h;
    reqI = int'(rq);
    if (r) begin
      mHolder[w] = -1;
      mCnt[w]    = 0;
      mLast[w]   = 3;
    end else if (mHolder[w] < 0) begin
      if (reqI != 0) begin
        h = pick(reqI, int'(md), mLast[w]);
        mHolder[w] = h; mCnt[w] = 1; mLast[w] = h;
      end
    end else begin
      others = reqI & ~(1 << mHolder[w]);
      if (((reqI >> mHolder[w]) & 1) == 0) begin
        if (others != 0) begin
          h = pick(others, int'(md), mLast[w]);
          mHolder[w] = h; mCnt[w] = 1; mLast[w] = h;
        end else begin
          mHolder[w] = -1; mCnt[w] = 0;
        end
      end else if (mMax[w] != 0 && mCnt[w] == mMax[w] && others != 0) begin
        h = pick(others, int'(md), mLast[w]);
        mHolder[w] = h; mCnt[w] = 1; mLast[w] = h;
      end else if (mCnt[w] < 15) begin
        mCnt[w] = mCnt[w] + 1;
      end
    end
    e.valid   = (mHolder[w] >= 0);
    e.id      = e.valid ? 2'(mHolder[w]) : 2'd0;
    e.gnt     = e.valid ? (4'b0001 << e.id) : 4'b0000;
    e.checkId = e.valid | r;
    return e;
  endfunction

  // Drives one cycle of inputs at the falling edge. The predicted response
  // for the next rising edge is queued for each instance.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic md);
    @(negedge clk);
    rst  = r;
    req  = rq;
    mode = md;
    qA.push_back(modelStep(0, r, rq, md));
    qB.push_back(modelStep(1, r, rq, md));
  endtask

  // Compares one instance's outputs against one predicted entry.
  task automatic checkOutput(input string name, input exp_t e,
                             input logic [3:0] g, input logic [1:0] id,
                             input logic v);
    logic ok;
    ok = (g === e.gnt) && (v === e.valid) && (!e.checkId || id === e.id);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s t=%0t gnt=%b id=%0d valid=%b expected gnt=%b id=%0d valid=%b",
               name, $time, g, id, v, e.gnt, e.id, e.valid);
    end
  endtask

  // Monitor: just after each rising edge, pops one prediction per instance
  // and checks it against what that instance presents.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (qA.size() > 0) checkOutput("arbA_maxhold2", qA.pop_front(), gntA, idA, validA);
      if (qB.size() > 0) checkOutput("arbB_unlimited", qB.pop_front(), gntB, idB, validB);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed scenarios first, then a randomized phase.
  initial begin
    logic [3:0] rq;
    logic       md;
    mHolder = '{-1, -1};
    mCnt    = '{0, 0};
    mLast   = '{3, 3};
    mMax    = '{2, 0};
    rst  = 1'b1;
    req  = 4'b0000;
    mode = 1'b0;

    // Reset state.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Fixed priority with all four requesting: index 3 wins.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b1111, 1'b0);

    // Round-robin from reset: each grant changes every hold-limit cycles.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b1111, 1'b1);

    // Back-to-back hand-off on release, then return to idle.
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0011, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // A sole requester keeps its grant well past the hold limit.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);

    // Reset during an active grant, then the first round-robin grant.
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b1111, 1'b1);

    // Two requesters held for a long time in round-robin mode.
    applyStimulus(1'b1, 4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'b1010, 1'b1);

    // Mode flip mid-grant.
    applyStimulus(1'b0, 4'b1110, 1'b0);
    applyStimulus(1'b0, 4'b1110, 1'b1);

    // Randomized traffic: requests persist for a while so expiry is exercised.
    rq = 4'b0000;
    md = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) md = ~md;
      applyStimulus(($urandom_range(0, 49) == 0), rq, md);
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (qA.size() + qB.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d expected pending=0", qA.size() + qB.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
